// File: rtl/sha256_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : sha256_ctrl_if
// Purpose  : Handshake and strobe bundle between a SHA-256 block requester
//            and the sha256_ctrl sequencer.
// Ports    : init, next          - start requests (requester -> controller)
//            block_load, iv_load - load strobes for schedule / IV
//            round_en, round_idx - per-round enable and round number
//            digest_update       - H += working vars strobe
//            ready, digest_valid - controller status
// Revision : 1.0 - initial release
//==============================================================================
interface sha256_ctrl_if;
   logic       init;
   logic       next;
   logic       block_load;
   logic       iv_load;
   logic       round_en;
   logic [5:0] round_idx;
   logic       digest_update;
   logic       ready;
   logic       digest_valid;

   // Requester side: issues starts, observes strobes and status.
   modport master (
      output init, next,
      input  block_load, iv_load, round_en, round_idx,
      input  digest_update, ready, digest_valid
   );

   // Controller side.
   modport slave (
      input  init, next,
      output block_load, iv_load, round_en, round_idx,
      output digest_update, ready, digest_valid
   );
endinterface
`default_nettype wire

// File: rtl/sha256_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : sha256_ctrl
// Purpose  : Sequencer for a SHA-256 compression datapath. A start (init or
//            next) in IDLE runs LOAD (1 cycle), ROUND (NUM_ROUNDS cycles) and
//            FINAL (1 cycle), then returns to IDLE with digest_valid set.
// Params   : NUM_ROUNDS - compression rounds per block, legal range 2..64
// Ports    : clk     - rising-edge clock
//            reset_n - asynchronous active-low reset
//            bus     - sha256_ctrl_if.slave (init/next in, strobes and
//                      status out)
// Revision : 1.0 - initial release
//==============================================================================
module sha256_ctrl #(
   parameter int NUM_ROUNDS = 64
) (
   input  wire logic     clk,
   input  wire logic     reset_n,
   sha256_ctrl_if.slave  bus
);

   localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      FINAL = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [5:0] round_cnt;
   logic [5:0] round_cnt_nxt;
   logic       kind_init;      // latched start kind: 1 = init, 0 = next
   logic       kind_init_nxt;
   logic       valid;
   logic       valid_nxt;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         round_cnt <= 6'd0;
         kind_init <= 1'b0;
         valid     <= 1'b0;
      end else begin
         state     <= state_nxt;
         round_cnt <= round_cnt_nxt;
         kind_init <= kind_init_nxt;
         valid     <= valid_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic. Starts are only looked at in IDLE, so requests raised
   // while a block is in flight are dropped rather than queued.
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      round_cnt_nxt = round_cnt;
      kind_init_nxt = kind_init;
      valid_nxt     = valid;
      case (state)
         IDLE: begin
            if (bus.init || bus.next) begin
               state_nxt     = LOAD;
               kind_init_nxt = bus.init;   // init wins when both are high
               valid_nxt     = 1'b0;
            end
         end
         LOAD: begin
            state_nxt     = ROUND;
            round_cnt_nxt = 6'd0;
         end
         ROUND: begin
            if (round_cnt == LAST_ROUND) begin
               state_nxt     = FINAL;
               round_cnt_nxt = 6'd0;       // index reads 0 outside ROUND
            end else begin
               round_cnt_nxt = round_cnt + 6'd1;
            end
         end
         FINAL: begin
            state_nxt = IDLE;
            valid_nxt = 1'b1;
         end
         default: begin
            state_nxt     = IDLE;
            round_cnt_nxt = 6'd0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs: decoded from registered state only, so they follow reset
   // immediately and have no path from init/next.
   //---------------------------------------------------------------------------
   assign bus.ready         = (state == IDLE);
   assign bus.block_load    = (state == LOAD);
   assign bus.iv_load       = (state == LOAD) && kind_init;
   assign bus.round_en      = (state == ROUND);
   assign bus.round_idx     = round_cnt;
   assign bus.digest_update = (state == FINAL);
   assign bus.digest_valid  = valid;

endmodule
`default_nettype wire

// File: doc/sha256_ctrl.md
SHA256_CTRL -- requirements
Module: sha256_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 64, number of compression rounds per block; legal range 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 init  input  1  start first block of a new message; datapath loads IV into digest registers.
REQ-005 next  input  1  start a subsequent block; the current digest is kept.
REQ-006 block_load  output  1  one-cycle strobe: load 512-bit block into message schedule and digest into working vars a..h.
REQ-007 iv_load  output  1  one-cycle strobe, coincident with block_load, only for init starts.
REQ-008 round_en  output  1  enables one round in the datapath this cycle.
REQ-009 round_idx  output  6  index of the round performed this cycle; selects K[t] and W[t].
REQ-010 digest_update  output  1  one-cycle strobe: H[i] <= H[i] + working var[i].
REQ-011 ready  output  1  high when a start is accepted.
REQ-012 digest_valid  output  1  digest holds the result of the last completed block.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, ROUND and FINAL, with only the transitions listed here.
REQ-014 IDLE: ready=1; init or next high SHALL go to LOAD next cycle; otherwise stay.
REQ-015 init and next high in the same cycle SHALL be treated as init.
REQ-016 Start accepted: digest_valid SHALL clear on the following edge; the kind (init/next) SHALL be latched.
REQ-017 LOAD lasts exactly 1 cycle: block_load=1, iv_load=1 only if latched kind is init; SHALL go to ROUND.
REQ-018 ROUND: round_en=1 every cycle; round_idx SHALL start at 0 and increment by 1 per cycle.
REQ-019 ROUND ends on the cycle with round_idx=NUM_ROUNDS-1; it SHALL last exactly NUM_ROUNDS cycles, then go to FINAL.
REQ-020 round_idx SHALL never exceed NUM_ROUNDS-1 and SHALL never wrap inside a block.
REQ-021 round_idx SHALL be 0 in IDLE, LOAD and FINAL.
REQ-022 FINAL lasts 1 cycle: digest_update=1; SHALL go to IDLE with digest_valid set on the same edge.
REQ-023 digest_valid SHALL stay 1 in IDLE until the next accepted start.
REQ-024 Latency: with start sampled at edge E0, digest_valid SHALL rise at edge E0+NUM_ROUNDS+2 (66 for 64).
REQ-025 ready SHALL be 0 in LOAD, ROUND and FINAL; init/next in those states SHALL be ignored, not queued.
REQ-026 Strobes block_load, iv_load and digest_update SHALL be 1 only in their named states, one cycle each per block.
REQ-027 round_en and digest_update SHALL never be high in the same cycle.
REQ-028 next with no prior init SHALL be accepted; digest content is the datapath's responsibility.
REQ-029 All outputs SHALL be registered or decoded from registered state only; no combinational path from init/next to any output.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, round_idx=0, ready=1, digest_valid=0 and all strobes 0, in any state.
REQ-031 A block interrupted by reset SHALL be abandoned, with no digest_update issued.
REQ-032 After reset_n rises, the first rising edge with init high SHALL be accepted.

Verification
REQ-033 Reset, then init pulse 1 cycle -> LOAD with block_load=iv_load=1; round_idx 0..63 over 64 round_en cycles; one digest_update; digest_valid=1 at E0+66.
REQ-034 After REQ-033, next pulse -> block_load=1 and iv_load=0; same 66-cycle sequence; digest_valid low from E0+1 to E0+65.
REQ-035 init and next high together in IDLE -> iv_load=1 on the LOAD cycle.
REQ-036 init and next pulsed at round_idx=10 and in FINAL -> ignored: round count and timing unchanged, ready=0; controller returns to IDLE with no extra block.
REQ-037 reset_n low asynchronously at round_idx=30 -> outputs reach reset values without a clock edge; no digest_update; after release, init gives a fresh full 66-cycle run.
REQ-038 NUM_ROUNDS=2 build, init -> round_idx 0,1, then FINAL; digest_valid at E0+4.
